// File: rtl/pipelined_add_tree.sv
// Pipelined N_IN-lane unsigned adder tree with a framed output accumulator.
// One register stage per tree level, then one accumulator/output stage.
// The whole pipeline advances together under a valid/ready handshake.
module pipelined_add_tree #(
  parameter int IN_W    = 17,
  parameter int N_IN    = 8,
  parameter int LOG2N   = 3,
  parameter int ACC_EXT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_IN*IN_W-1:0]            in_data,
  input  logic                            in_first,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IN_W+LOG2N+ACC_EXT-1:0]   out_data,
  output logic                            out_ovf
);

  localparam int SUM_W = IN_W + LOG2N;
  localparam int OUT_W = SUM_W + ACC_EXT;
  localparam int HALF  = N_IN / 2;
  localparam int TOP   = LOG2N - 1;

  if ((N_IN < 2) || ((1 << LOG2N) != N_IN)) begin : g_bad_cfg
    $error("pipelined_add_tree: N_IN must be a power of two >= 2 and equal 2**LOG2N");
  end

  logic                 advance;
  logic                 in_fire;

  // Input lanes, zero-extended; forced to zero when no transfer happens so
  // undriven data on an idle bus never enters the tree.
  logic [SUM_W-1:0]     lane [N_IN];

  // tree_q[l] holds the results of tree level l+1; only the first
  // N_IN >> (l+1) entries of each row carry data.
  logic [SUM_W-1:0]     tree_d [LOG2N][HALF];
  logic [SUM_W-1:0]     tree_q [LOG2N][HALF];
  logic [LOG2N-1:0]     tvld_d, tvld_q;
  logic [LOG2N-1:0]     tfirst_d, tfirst_q;
  logic [LOG2N-1:0]     tlast_d, tlast_q;

  logic [OUT_W-1:0]     acc_d, acc_q;
  logic                 acc_ovf_d, acc_ovf_q;
  logic [OUT_W-1:0]     out_data_d, out_data_q;
  logic                 out_ovf_d, out_ovf_q;
  logic                 out_valid_d, out_valid_q;

  logic [OUT_W-1:0]     sum_ext;
  logic [OUT_W-1:0]     base;
  logic                 base_ovf;
  logic [OUT_W:0]       add_full;

  // Handshake: every stage moves unless a finished result is waiting on downstream.
  always_comb begin
    advance = !out_valid_q || out_ready;
    in_fire = in_valid && advance;
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Slice the input bus into zero-extended lanes, gated by the transfer.
  always_comb begin
    for (int unsigned k = 0; k < N_IN; k++) begin
      lane[k] = '0;
      if (in_fire) begin
        lane[k] = SUM_W'(in_data[IN_W*k +: IN_W]);
      end
    end
  end

  // Tree levels: pairwise sums of the previous level; flags ride alongside.
  always_comb begin
    tree_d   = tree_q;
    tvld_d   = tvld_q;
    tfirst_d = tfirst_q;
    tlast_d  = tlast_q;
    if (advance) begin
      tvld_d[0]   = in_fire;
      tfirst_d[0] = in_fire && in_first;
      tlast_d[0]  = in_fire && in_last;
      for (int unsigned j = 0; j < HALF; j++) begin
        tree_d[0][j] = lane[2*j] + lane[2*j+1];
      end
      for (int unsigned l = 1; l < LOG2N; l++) begin
        tvld_d[l]   = tvld_q[l-1];
        tfirst_d[l] = tfirst_q[l-1];
        tlast_d[l]  = tlast_q[l-1];
        for (int unsigned j = 0; j < (HALF >> l); j++) begin
          tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
        end
      end
    end
  end

  // Tree stage control flags (valid/first/last) with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvld_q   <= '0;
      tfirst_q <= '0;
      tlast_q  <= '0;
    end else begin
      tvld_q   <= tvld_d;
      tfirst_q <= tfirst_d;
      tlast_q  <= tlast_d;
    end
  end

  // Tree partial-sum data registers; contents are qualified by tvld_q.
  always_ff @(posedge clk) begin
    tree_q <= tree_d;
  end

  // Accumulator: restart on first, emit and clear on last, sticky wrap flag per frame.
  always_comb begin
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    sum_ext     = OUT_W'(tree_q[TOP][0]);
    base        = tfirst_q[TOP] ? '0 : acc_q;
    base_ovf    = tfirst_q[TOP] ? 1'b0 : acc_ovf_q;
    add_full    = {1'b0, base} + {1'b0, sum_ext};
    if (advance) begin
      // advance with out_valid set means the held result is being taken now
      out_valid_d = 1'b0;
      if (tvld_q[TOP]) begin
        if (tlast_q[TOP]) begin
          out_data_d  = add_full[OUT_W-1:0];
          out_ovf_d   = base_ovf || add_full[OUT_W];
          out_valid_d = 1'b1;
          acc_d       = '0;
          acc_ovf_d   = 1'b0;
        end else begin
          acc_d       = add_full[OUT_W-1:0];
          acc_ovf_d   = base_ovf || add_full[OUT_W];
        end
      end
    end
  end

  // Accumulator and output registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pipelined_add_tree.sv
// Directed bench for pipelined_add_tree at default parameters (8 lanes x 17 bits, 24-bit out).
module tb_pipelined_add_tree;

  localparam int IN_W  = 17;
  localparam int N_IN  = 8;
  localparam int NW    = IN_W * N_IN;
  localparam int OUT_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NW-1:0]    in_data;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [OUT_W-1:0] rx_d[$];
  logic             rx_o[$];
  int               rx_c[$];

  typedef struct {
    logic [NW-1:0]    data;
    logic [OUT_W-1:0] exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t tbl[8];

  pipelined_add_tree #(.IN_W(17), .N_IN(8), .LOG2N(3), .ACC_EXT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output transfer (sampled mid-cycle, before the transferring edge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rx_d.push_back(out_data);
      rx_o.push_back(out_ovf);
      rx_c.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [NW-1:0] uni(input logic [IN_W-1:0] v);
    logic [NW-1:0] d;
    for (int k = 0; k < N_IN; k++) d[IN_W*k +: IN_W] = v;
    return d;
  endfunction

  function automatic logic [NW-1:0] seq();
    logic [NW-1:0] d;
    for (int k = 0; k < N_IN; k++) d[IN_W*k +: IN_W] = IN_W'(k + 1);
    return d;
  endfunction

  // Present one vector, hold it until accepted; leaves junk on the idle bus.
  task automatic send(input logic [NW-1:0] d, input logic f, input logic l, output int waited);
    logic acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 64'(n), 64'd0);
    waited   = n;
    in_valid = 1'b0;
    in_data  = NW'({5{$urandom()}});
    in_first = 1'($urandom_range(1, 0));
    in_last  = 1'($urandom_range(1, 0));
  endtask

  task automatic wait_rx(input string nm, input int n);
    int k;
    k = 0;
    while (rx_d.size() < n && k < 60) begin
      step();
      k++;
    end
    chk(nm, 64'(rx_d.size()), 64'(n));
  endtask

  task automatic clear_rx();
    rx_d.delete();
    rx_o.delete();
    rx_c.delete();
  endtask

  initial begin
    int w;
    int total;
    int n;
    logic [OUT_W-1:0] held;
    logic [NW-1:0] d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    // Directed single-vector frames with hand-computed sums.
    tbl[0].data = uni(17'h1FFFF);   tbl[0].exp_data = 24'h0FFFF8; tbl[0].exp_ovf = 1'b0;
    tbl[1].data = seq();            tbl[1].exp_data = 24'd36;     tbl[1].exp_ovf = 1'b0;
    tbl[2].data = '0;               tbl[2].exp_data = 24'd0;      tbl[2].exp_ovf = 1'b0;
    tbl[3].data = uni(17'd1);       tbl[3].exp_data = 24'd8;      tbl[3].exp_ovf = 1'b0;
    d = '0; d[16:0] = 17'h1FFFF;
    tbl[4].data = d;                tbl[4].exp_data = 24'h01FFFF; tbl[4].exp_ovf = 1'b0;
    tbl[5].data = uni(17'h10000);   tbl[5].exp_data = 24'h080000; tbl[5].exp_ovf = 1'b0;
    d = '0;
    for (int k = 0; k < N_IN; k += 2) d[IN_W*k +: IN_W] = 17'h1FFFF;
    tbl[6].data = d;                tbl[6].exp_data = 24'h07FFFC; tbl[6].exp_ovf = 1'b0;
    d = '0; d[NW-1 -: IN_W] = 17'h1ABCD;
    tbl[7].data = d;                tbl[7].exp_data = 24'h01ABCD; tbl[7].exp_ovf = 1'b0;

    // Reset state
    idle(2);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    idle(2);

    // Max lanes, latency LOG2N+1
    clear_rx();
    in_valid = 1'b1; in_data = uni(17'h1FFFF); in_first = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_data = NW'({5{$urandom()}});
    n = 1;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("lat_cycles", 64'(n), 64'd4);
    chk("lat_data", 64'(out_data), 64'h0FFFF8);
    chk("lat_ovf", 64'(out_ovf), 64'd0);
    idle(4);

    // Table vectors streamed back to back
    clear_rx();
    foreach (tbl[i]) send(tbl[i].data, 1'b1, 1'b1, w);
    wait_rx("tbl_count", 8);
    for (int i = 0; i < 8 && i < rx_d.size(); i++) begin
      chk($sformatf("tbl_data_%0d", i), 64'(rx_d[i]), 64'(tbl[i].exp_data));
      chk($sformatf("tbl_ovf_%0d", i), 64'(rx_o[i]), 64'(tbl[i].exp_ovf));
    end
    idle(4);

    // Streaming: 10 vectors, one per cycle in and out
    clear_rx();
    total = 0;
    for (int i = 0; i < 10; i++) begin
      send(seq(), 1'b1, 1'b1, w);
      total += w;
    end
    chk("stream_no_stall", 64'(total), 64'd10);
    wait_rx("stream_count", 10);
    for (int i = 0; i < 10 && i < rx_d.size(); i++) begin
      chk($sformatf("stream_data_%0d", i), 64'(rx_d[i]), 64'd36);
      chk($sformatf("stream_cyc_%0d", i), 64'(rx_c[i] - rx_c[0]), 64'(i));
    end
    idle(4);

    // Three-vector frame
    clear_rx();
    send(uni(17'd1), 1'b1, 1'b0, w);
    send(uni(17'd1), 1'b0, 1'b0, w);
    send(uni(17'd1), 1'b0, 1'b1, w);
    idle(8);
    chk("frame_count", 64'(rx_d.size()), 64'd1);
    if (rx_d.size() > 0) begin
      chk("frame_data", 64'(rx_d[0]), 64'd24);
      chk("frame_ovf", 64'(rx_o[0]), 64'd0);
    end

    // Backpressure: stall 5 cycles under a full input stream
    clear_rx();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(uni(IN_W'(i + 1)), 1'b1, 1'b1, w);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        held = out_data;
        chk("bp_head", 64'(held), 64'd8);
        for (int c = 0; c < 5; c++) begin
          chk($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
          chk($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
          chk($sformatf("bp_stable_%0d", c), 64'(out_data), 64'(held));
          step();
        end
        out_ready = 1'b1;
      end
    join
    wait_rx("bp_count", 6);
    for (int i = 0; i < 6 && i < rx_d.size(); i++)
      chk($sformatf("bp_order_%0d", i), 64'(rx_d[i]), 64'(8 * (i + 1)));
    idle(4);

    // Overflow: 17-vector frame of max lanes, then a clean frame
    clear_rx();
    for (int i = 0; i < 17; i++) send(uni(17'h1FFFF), 1'(i == 0), 1'(i == 16), w);
    idle(8);
    chk("ovf_count", 64'(rx_d.size()), 64'd1);
    if (rx_d.size() > 0) begin
      chk("ovf_data", 64'(rx_d[0]), 64'd1048440);
      chk("ovf_flag", 64'(rx_o[0]), 64'd1);
    end
    clear_rx();
    send(uni(17'd1), 1'b1, 1'b1, w);
    idle(8);
    chk("ovf_next_count", 64'(rx_d.size()), 64'd1);
    if (rx_d.size() > 0) begin
      chk("ovf_next_data", 64'(rx_d[0]), 64'd8);
      chk("ovf_next_flag", 64'(rx_o[0]), 64'd0);
    end

    // last without first continues from a cleared acc; first discards an open frame
    clear_rx();
    send(uni(17'd1), 1'b0, 1'b1, w);
    send(uni(17'd1), 1'b1, 1'b0, w);
    send(uni(17'd2), 1'b1, 1'b0, w);
    send(uni(17'd1), 1'b0, 1'b1, w);
    wait_rx("cont_count", 2);
    if (rx_d.size() >= 2) begin
      chk("cont_no_first", 64'(rx_d[0]), 64'd8);
      chk("first_discards", 64'(rx_d[1]), 64'd24);
    end
    idle(6);

    // Reset mid-frame with an output pending
    clear_rx();
    send(uni(17'd2), 1'b1, 1'b1, w);
    send(uni(17'd1), 1'b1, 1'b0, w);
    send(uni(17'd1), 1'b0, 1'b0, w);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    #2;
    rst = 1'b0;
    idle(6);
    chk("mid_dropped", 64'(rx_d.size()), 64'd0);
    send(uni(17'd1), 1'b0, 1'b1, w);
    send(uni(17'd1), 1'b1, 1'b1, w);
    wait_rx("mid_post_count", 2);
    if (rx_d.size() >= 2) begin
      chk("mid_acc_cleared", 64'(rx_d[0]), 64'd8);
      chk("mid_post_data", 64'(rx_d[1]), 64'd8);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
